// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared encodings and types for the memory stage
package pipeline_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {LSU_IDLE = 1'b0, LSU_BUSY = 1'b1} lsu_state_e;

  typedef struct packed {
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic [31:0] aluresult;
    logic [31:0] readdata;
    logic [4:0]  rd;
    logic [31:0] pcplus4;
  } memwb_t;

  typedef struct packed {
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [4:0]  rd;
    logic [31:0] pcplus4;
  } lsu_req_t;
endpackage

// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - data memory req/ack bus between the LSU and memory
interface mem_stage_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane placement and load lane extraction/extension
module lsu_align
  import pipeline_pkg::*;
(
  input  logic        st_we,
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wd,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);
  logic [31:0] ld_shift;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_wd;
    if (st_we) begin
      case (st_size)
        2'b00: begin
          st_be    = 4'b0001 << st_addr_lo;
          st_wdata = {4{st_wd[7:0]}};
        end
        2'b01: begin
          st_be    = 4'b0011 << st_addr_lo;
          st_wdata = {2{st_wd[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Shift the addressed lane down to bit 0 before extending.
  assign ld_shift = ld_rdata >> {ld_addr_lo, 3'b000};

  always_comb begin
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_W:    ld_data = ld_shift;
      F3_BU:   ld_data = {24'h0, ld_shift[7:0]};
      F3_HU:   ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = 32'h0;
    endcase
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory stage: load/store sequencer, stall and MEM/WB register
module mem_stage_lsu
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             regwrite_m,
  input  logic [1:0]       resultsrc_m,
  input  logic             memwrite_m,
  input  logic [31:0]      aluresult_m,
  input  logic [31:0]      writedata_m,
  input  logic [4:0]       rd_m,
  input  logic [31:0]      pcplus4_m,
  input  logic [2:0]       funct3_m,
  mem_stage_lsu_if.master  dmem,
  output logic             stall_m,
  output logic             regwrite_w,
  output logic [1:0]       resultsrc_w,
  output logic [31:0]      aluresult_w,
  output logic [31:0]      readdata_w,
  output logic [4:0]       rd_w,
  output logic [31:0]      pcplus4_w,
  output logic             fault_w,
  output logic [31:0]      fault_addr_w
);
  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lsu_req_t         req_q, req_d;
  memwb_t           wb_q, wb_d;
  logic             fault_q, fault_d;
  logic [31:0]      fault_addr_q, fault_addr_d;

  logic        mem_op, size_ok, misaligned, timeout_hit, lat_is_load;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  lsu_align u_align (
    .st_we      (memwrite_m),
    .st_size    (funct3_m[1:0]),
    .st_addr_lo (aluresult_m[1:0]),
    .st_wd      (writedata_m),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .ld_funct3  (req_q.funct3),
    .ld_addr_lo (req_q.addr[1:0]),
    .ld_rdata   (dmem.rdata),
    .ld_data    (ld_data)
  );

  always_comb begin
    mem_op = (resultsrc_m == RES_MEM) || memwrite_m;
    if (memwrite_m) size_ok = funct3_m inside {F3_B, F3_H, F3_W};
    else            size_ok = funct3_m inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    misaligned = ((funct3_m[1:0] == 2'b01) && aluresult_m[0]) ||
                 ((funct3_m[1:0] == 2'b10) && (aluresult_m[1:0] != 2'b00));
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign lat_is_load = (req_q.resultsrc == RES_MEM) && !req_q.we;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    wb_d         = '0;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    stall_m      = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (!mem_op) begin
          wb_d = '{regwrite: regwrite_m, resultsrc: resultsrc_m, aluresult: aluresult_m,
                   readdata: 32'h0, rd: rd_m, pcplus4: pcplus4_m};
        end else if (!size_ok || misaligned) begin
          fault_d      = 1'b1;
          fault_addr_d = aluresult_m;
        end else begin
          stall_m = 1'b1;
          req_d   = '{regwrite: regwrite_m, resultsrc: resultsrc_m, we: memwrite_m,
                      funct3: funct3_m, addr: aluresult_m, wdata: st_wdata, be: st_be,
                      rd: rd_m, pcplus4: pcplus4_m};
          cnt_d   = '0;
          state_d = LSU_BUSY;
        end
      end
      LSU_BUSY: begin
        if (dmem.ack) begin
          wb_d = '{regwrite: req_q.regwrite, resultsrc: req_q.resultsrc, aluresult: req_q.addr,
                   readdata: lat_is_load ? ld_data : 32'h0, rd: req_q.rd, pcplus4: req_q.pcplus4};
          cnt_d   = '0;
          state_d = LSU_IDLE;
        end else if (timeout_hit) begin
          // Give up on the bus; release the pipeline so the fault can be taken.
          fault_d      = 1'b1;
          fault_addr_d = req_q.addr;
          cnt_d        = '0;
          state_d      = LSU_IDLE;
        end else begin
          stall_m = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LSU_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      wb_q         <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      wb_q         <= wb_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign dmem.req   = (state_q == LSU_BUSY);
  assign dmem.we    = req_q.we;
  assign dmem.addr  = {req_q.addr[31:2], 2'b00};
  assign dmem.be    = req_q.be;
  assign dmem.wdata = req_q.wdata;

  assign regwrite_w   = wb_q.regwrite;
  assign resultsrc_w  = wb_q.resultsrc;
  assign aluresult_w  = wb_q.aluresult;
  assign readdata_w   = wb_q.readdata;
  assign rd_w         = wb_q.rd;
  assign pcplus4_w    = wb_q.pcplus4;
  assign fault_w      = fault_q;
  assign fault_addr_w = fault_addr_q;
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory stage of the 5-stage pipeline. It sits directly downstream of the EX/MEM register and consumes that register's outputs. It performs byte/half/word loads and stores to data memory over a req/ack handshake and stalls the front of the pipeline while an access is outstanding. It also contains the MEM/WB pipeline register, which drives the writeback mux and the forwarding unit.

Parameters:
TIMEOUT, 16, max BUSY cycles waiting for dmem_ack before a bus fault (>=1)
CNT_W, 5, width of wait counter; must hold TIMEOUT

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
regwrite_m  in  1  register write enable from EX/MEM
resultsrc_m  in  2  result select: 00 ALU, 01 load data, 10 PC+4
memwrite_m  in  1  store enable
aluresult_m  in  32  ALU result, which is also the memory address
writedata_m  in  32  store data (rs2)
rd_m  in  5  destination register
pcplus4_m  in  32  PC+4
funct3_m  in  3  access size/sign (RV32I load/store encoding)
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  1 = write
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  32  store data, lane-replicated
dmem_be  out  4  byte enables
dmem_ack  in  1  access complete this cycle; rdata valid on loads
dmem_rdata  in  32  read word
stall_m  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
regwrite_w  out  1  MEM/WB register write enable
resultsrc_w  out  2  MEM/WB result select
aluresult_w  out  32  MEM/WB ALU result
readdata_w  out  32  MEM/WB extended load data
rd_w  out  5  MEM/WB destination register
pcplus4_w  out  32  MEM/WB PC+4
fault_w  out  1  one-cycle flag: misaligned, illegal size or timeout
fault_addr_w  out  32  faulting byte address, valid while fault_w=1

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, dmem_req=0. Every registered output is 0. Reset mid-access drops dmem_req immediately and discards the access.
- Memory op = (resultsrc_m==01) | memwrite_m. Legal funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. For stores only 000/001/010 are legal.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- States: IDLE, BUSY.
- IDLE, non-memory op: MEM/WB loads the inputs on the next edge (1-cycle latency). readdata_w=0, stall_m=0.
- IDLE, illegal or misaligned memory op:
  - No request is issued and stall_m=0.
  - Next edge loads a bubble (regwrite_w=0, resultsrc_w=00) with fault_w=1 and fault_addr_w=aluresult_m.
- IDLE, legal memory op:
  - stall_m=1 (combinational).
  - Latch addr, funct3, be, wdata, we and the control/rd/pcplus4 fields.
  - MEM/WB loads a bubble; go to BUSY.
- BUSY, outputs:
  - dmem_req=1, with addr/we/be/wdata driven from latches and stable until ack.
  - stall_m = ~dmem_ack.
- BUSY, dmem_ack=1:
  - MEM/WB loads the latched fields; loads also load the extracted read data.
  - Counter clears; go to IDLE. EX/MEM advances on the same edge.
- BUSY, dmem_ack=0:
  - MEM/WB loads a bubble and the counter increments.
  - When the counter reaches TIMEOUT-1 without ack: drop req, load a bubble with fault_w=1 and fault_addr_w=latched address, stall_m=0 that cycle, go to IDLE.
- A late ack arriving in IDLE is ignored.
- Minimum memory-op latency: 2 cycles, with 1 stall cycle.
- Store lanes:
  - SB: be=0001<<a[1:0], wdata={4{wd[7:0]}}.
  - SH: be=0011<<a[1:0], wdata={2{wd[15:0]}}.
  - SW: be=1111.
- Loads: dmem_we=0, be=1111. The lane is selected by latched a[1:0]. Sign- or zero-extend per funct3 to 32 bits.
- fault_w is high for exactly one cycle per fault. fault_addr_w holds its value otherwise.

Decomposition:
- Shared package (pipeline_pkg): funct3 load/store encodings, resultsrc encodings (RES_ALU/RES_MEM/RES_PC4), LSU state enum.
- One natural sub-module, lsu_align: combinational. It generates be/wdata and performs load lane extraction and extension. Reused by any future cache path.

Test Plan:
- ADD result 0x0000_0010, rd=5, regwrite=1 -> next cycle aluresult_w=0x10, rd_w=5, regwrite_w=1, stall_m never high.
- SW wd=0xDEADBEEF @0x100 with ack on first BUSY cycle -> dmem_addr=0x100, be=1111, we=1, stall_m high 1 cycle, regwrite_w=0.
- LB @0x103 with rdata=0x80FF_1234 and ack after 3 cycles -> be=1111, stall 4 cycles, readdata_w=0xFFFF_FF80. LBU on the same data -> 0x0000_0080.
- SH wd=0x0000_ABCD @0x102 -> be=1100, wdata=0xABCD_ABCD. LH @0x101 -> no req, fault_w=1, fault_addr_w=0x101, regwrite_w=0.
- LW with no ack, TIMEOUT=16 -> req held exactly 16 cycles then dropped, fault_w pulse, stall_m released. A late ack is ignored.
- rst_n low mid-BUSY -> dmem_req=0 immediately, all outputs 0. After release, the next ADD passes normally.
